// File: rtl/key_ctrl_if.sv
// Push-button controller bus: raw buttons in, debounced levels and key pulses out.
interface key_ctrl_if;
  logic [3:0] btn_raw;
  logic [3:0] op_keys;
  logic [3:0] key_state;
  logic       any_press;

  modport master (output btn_raw, input op_keys, input key_state, input any_press);
  modport slave  (input btn_raw, output op_keys, output key_state, output any_press);
endinterface

// File: rtl/key_ctrl.sv
// Four-key synchronizer, debouncer and press/auto-repeat pulse generator.
// Every output is a flop; btn_raw only reaches the first synchronizer stage.
module key_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 12500000,
  parameter int unsigned REPEAT_RATE     = 5000000,
  parameter logic [3:0]  REPEAT_MASK     = 4'b1110
) (
  input  logic        clk,
  input  logic        rst,
  key_ctrl_if.slave   bus
);

  localparam int unsigned DB_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [23:0]     DLY_LAST = 24'(REPEAT_DELAY - 1);
  localparam logic [23:0]     DLY_SAT  = 24'(REPEAT_DELAY);
  localparam logic [23:0]     RPT_LAST = 24'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    IDLE,
    HELD_DELAY,
    HELD_REPEAT
  } state_t;

  logic [3:0]      r_sync1;
  logic [3:0]      r_sync2;
  logic [DB_W-1:0] r_db_cnt [4];
  logic [3:0]      r_key;
  state_t          r_state  [4];
  logic [23:0]     r_rep_cnt[4];
  logic [3:0]      r_op;
  logic            r_any;

  logic [DB_W-1:0] w_db_cnt_next [4];
  logic [3:0]      w_key_next;
  state_t          w_state_next  [4];
  logic [23:0]     w_rep_cnt_next[4];
  logic [3:0]      w_pulse;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_key   <= '0;
      r_op    <= '0;
      r_any   <= 1'b0;
      for (int unsigned k = 0; k < 4; k++) begin
        r_db_cnt[k]  <= '0;
        r_state[k]   <= IDLE;
        r_rep_cnt[k] <= '0;
      end
    end else begin
      r_sync1 <= bus.btn_raw;
      r_sync2 <= r_sync1;
      r_key   <= w_key_next;
      r_op    <= w_pulse;
      r_any   <= |w_pulse;
      for (int unsigned k = 0; k < 4; k++) begin
        r_db_cnt[k]  <= w_db_cnt_next[k];
        r_state[k]   <= w_state_next[k];
        r_rep_cnt[k] <= w_rep_cnt_next[k];
      end
    end
  end

  // FSM decisions use the next debounced level so the press pulse lands on the
  // same edge key_state rises, and a release can never coincide with a repeat.
  always_comb begin
    w_key_next = r_key;
    w_pulse    = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      w_db_cnt_next[k]  = '0;
      w_state_next[k]   = r_state[k];
      w_rep_cnt_next[k] = r_rep_cnt[k];

      if (r_sync2[k] != r_key[k]) begin
        if (r_db_cnt[k] == DB_LAST) begin
          w_key_next[k] = ~r_key[k];
        end else begin
          w_db_cnt_next[k] = r_db_cnt[k] + DB_W'(1);
        end
      end

      case (r_state[k])
        IDLE: begin
          w_rep_cnt_next[k] = '0;
          if (w_key_next[k]) begin
            w_pulse[k]      = 1'b1;
            w_state_next[k] = HELD_DELAY;
          end
        end
        HELD_DELAY: begin
          if (!w_key_next[k]) begin
            w_state_next[k]   = IDLE;
            w_rep_cnt_next[k] = '0;
          end else if (REPEAT_MASK[k] && (r_rep_cnt[k] == DLY_LAST)) begin
            w_pulse[k]        = 1'b1;
            w_rep_cnt_next[k] = '0;
            w_state_next[k]   = HELD_REPEAT;
          end else if (r_rep_cnt[k] != DLY_SAT) begin
            w_rep_cnt_next[k] = r_rep_cnt[k] + 24'd1;
          end
        end
        HELD_REPEAT: begin
          if (!w_key_next[k]) begin
            w_state_next[k]   = IDLE;
            w_rep_cnt_next[k] = '0;
          end else if (r_rep_cnt[k] == RPT_LAST) begin
            w_pulse[k]        = 1'b1;
            w_rep_cnt_next[k] = '0;
          end else if (r_rep_cnt[k] != 24'hFF_FFFF) begin
            w_rep_cnt_next[k] = r_rep_cnt[k] + 24'd1;
          end
        end
        default: begin
          w_state_next[k]   = IDLE;
          w_rep_cnt_next[k] = '0;
        end
      endcase
    end
  end

  assign bus.op_keys   = r_op;
  assign bus.key_state = r_key;
  assign bus.any_press = r_any;

endmodule

// File: tb/tb_key_ctrl.sv
// Directed bench for key_ctrl with a cycle-stamped scoreboard of expected op_keys pulses.
module tb_key_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  key_ctrl_if u_if ();

  key_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_RATE    (8),
    .REPEAT_MASK    (4'b1110)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(u_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic [3:0]  keys;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc   = 0;
  int unsigned tests = 0;
  int unsigned fails = 0;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s @cyc %0d: observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic push(input int unsigned c, input logic [3:0] k);
    sb.push_back('{c, k});
  endtask

  // One clock edge, then compare pulses against the scoreboard (zero unless scheduled).
  task automatic tick();
    logic [3:0] exp;
    @(posedge clk);
    cyc++;
    #1;
    exp = '0;
    if (sb.size() != 0 && sb[0].cyc == cyc) begin
      exp = sb[0].keys;
      void'(sb.pop_front());
    end
    chk("op_keys", u_if.op_keys, exp);
    chk("any_press", {3'b000, u_if.any_press}, {3'b000, |exp});
  endtask

  task automatic run_to(input int unsigned target);
    while (cyc < target) tick();
  endtask

  int unsigned t0;
  int unsigned t1;

  initial begin
    u_if.btn_raw = '0;

    // Reset state
    #1;
    chk("rst_key_state", u_if.key_state, 4'b0000);
    chk("rst_op_keys", u_if.op_keys, 4'b0000);
    repeat (3) tick();
    rst = 1'b0;
    repeat (5) tick();

    // Clean press on left, auto-repeat, release while repeating
    t0 = cyc;
    u_if.btn_raw = 4'b0100;
    push(t0 + 6, 4'b0100);
    push(t0 + 26, 4'b0100);
    push(t0 + 34, 4'b0100);
    push(t0 + 42, 4'b0100);
    push(t0 + 50, 4'b0100);
    run_to(t0 + 5);
    chk("clean_ks_before", u_if.key_state, 4'b0000);
    run_to(t0 + 6);
    chk("clean_ks_rise", u_if.key_state, 4'b0100);
    run_to(t0 + 45);
    u_if.btn_raw = 4'b0000;
    run_to(t0 + 50);
    chk("clean_ks_held", u_if.key_state, 4'b0100);
    run_to(t0 + 51);
    chk("clean_ks_fall", u_if.key_state, 4'b0000);
    repeat (10) tick();

    // Bounce on down: 2-cycle toggling never survives debounce
    for (int i = 0; i < 30; i++) begin
      u_if.btn_raw = {2'b00, ~i[1], 1'b0};
      tick();
      chk("bounce_ks", u_if.key_state, 4'b0000);
    end
    u_if.btn_raw = 4'b0000;
    repeat (10) tick();

    // Non-repeating up key: single pulse, silent release
    t0 = cyc;
    u_if.btn_raw = 4'b0001;
    push(t0 + 6, 4'b0001);
    run_to(t0 + 100);
    u_if.btn_raw = 4'b0000;
    run_to(t0 + 105);
    chk("norpt_ks_held", u_if.key_state, 4'b0001);
    run_to(t0 + 106);
    chk("norpt_ks_fall", u_if.key_state, 4'b0000);
    repeat (10) tick();

    // Simultaneous left+right: coincident pulses, no arbitration
    t0 = cyc;
    u_if.btn_raw = 4'b1100;
    push(t0 + 6, 4'b1100);
    push(t0 + 26, 4'b1100);
    push(t0 + 34, 4'b1100);
    push(t0 + 42, 4'b1100);
    push(t0 + 50, 4'b1100);
    run_to(t0 + 6);
    chk("simul_ks_rise", u_if.key_state, 4'b1100);
    run_to(t0 + 45);
    u_if.btn_raw = 4'b0000;
    run_to(t0 + 51);
    chk("simul_ks_fall", u_if.key_state, 4'b0000);
    repeat (10) tick();

    // Early release of right before the repeat delay expires
    t0 = cyc;
    u_if.btn_raw = 4'b1000;
    push(t0 + 6, 4'b1000);
    run_to(t0 + 15);
    u_if.btn_raw = 4'b0000;
    run_to(t0 + 20);
    chk("early_ks_held", u_if.key_state, 4'b1000);
    run_to(t0 + 21);
    chk("early_ks_fall", u_if.key_state, 4'b0000);
    run_to(t0 + 40);

    // Reset mid-repeat with left held: pending repeat dropped, fresh press afterwards
    t0 = cyc;
    u_if.btn_raw = 4'b0100;
    push(t0 + 6, 4'b0100);
    push(t0 + 26, 4'b0100);
    run_to(t0 + 30);
    rst = 1'b1;
    #1;
    chk("rst_async_ks", u_if.key_state, 4'b0000);
    chk("rst_async_op", u_if.op_keys, 4'b0000);
    chk("rst_async_any", {3'b000, u_if.any_press}, 4'b0000);
    run_to(t0 + 33);
    rst = 1'b0;
    t1 = cyc;
    push(t1 + 6, 4'b0100);
    push(t1 + 26, 4'b0100);
    push(t1 + 34, 4'b0100);
    run_to(t1 + 5);
    chk("rst_fresh_ks_before", u_if.key_state, 4'b0000);
    run_to(t1 + 30);
    u_if.btn_raw = 4'b0000;
    run_to(t1 + 45);
    chk("rst_fresh_ks_fall", u_if.key_state, 4'b0000);

    chk("scoreboard_drained", 4'(sb.size()), 4'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/key_ctrl.md
KEY_CTRL -- requirements
Module: key_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, SHALL be the number of consecutive stable synchronized samples needed to change a debounced key level (10 ms at 50 MHz).
REQ-002 Parameter REPEAT_DELAY, default 12500000, SHALL be the number of cycles from the initial press pulse to the first auto-repeat pulse.
REQ-003 Parameter REPEAT_RATE, default 5000000, SHALL be the number of cycles between subsequent auto-repeat pulses.
REQ-004 Parameter REPEAT_MASK, default 4'b1110, SHALL select the keys that auto-repeat (bit order as op_keys; up/rotate does not repeat by default).
REQ-005 clk  input  1  SHALL be the single system clock.
REQ-006 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-007 btn_raw  input  4  SHALL be the raw, asynchronous, bouncing push-buttons: [0] up, [1] down, [2] left, [3] right.
REQ-008 op_keys  output  4  SHALL carry one-cycle press/repeat pulses to GAME_CTRL.op_keys, using the same bit order.
REQ-009 key_state  output  4  SHALL be the registered debounced level of each key.
REQ-010 any_press  output  1  SHALL be the registered OR of the op_keys pulse sources, aligned with op_keys.

Function
REQ-011 Each btn_raw bit SHALL pass through a 2-flop synchronizer; no other logic SHALL use btn_raw directly.
REQ-012 Each key SHALL have an independent debouncer, counter width ceil(log2(DEBOUNCE_CYCLES+1)), with no cross-key coupling.
REQ-013 Debounce: synchronized sample != key_state -> counter +1; sample == key_state -> counter cleared to 0.
REQ-014 When the counter would reach DEBOUNCE_CYCLES, key_state SHALL toggle and the counter SHALL clear in the same edge.
REQ-015 Latency: key_state SHALL rise on the (DEBOUNCE_CYCLES+2)th rising edge counting the first edge that samples btn_raw high; release SHALL be symmetric.
REQ-016 Any glitch shorter than DEBOUNCE_CYCLES synchronized samples SHALL leave key_state and op_keys unchanged.
REQ-017 Each key SHALL run a 3-state FSM: IDLE, HELD_DELAY, HELD_REPEAT.
REQ-018 IDLE -> HELD_DELAY on key_state 0->1; op_keys[k] SHALL pulse high for exactly the cycle key_state first reads 1.
REQ-019 HELD_DELAY: a 24-bit repeat counter SHALL count cycles; at REPEAT_DELAY, if REPEAT_MASK[k]=1, op_keys[k] SHALL pulse, the counter SHALL clear, and the FSM SHALL go to HELD_REPEAT.
REQ-020 HELD_REPEAT: op_keys[k] SHALL pulse every REPEAT_RATE cycles while key_state[k]=1.
REQ-021 If REPEAT_MASK[k]=0, the FSM SHALL remain in HELD_DELAY with the counter saturated, and SHALL generate no further pulses.
REQ-022 From any state, key_state[k]=0 SHALL force IDLE and clear the repeat counter in the same edge; no pulse SHALL be generated on release.
REQ-023 The repeat counter SHALL saturate and never wrap.
REQ-024 Simultaneous presses, including left+right, SHALL produce simultaneous pulses without arbitration; GAME_CTRL handles cancellation.
REQ-025 op_keys SHALL never be high for two consecutive cycles on the same bit, for any REPEAT_RATE >= 2.
REQ-026 op_keys and any_press SHALL be driven directly from flops, with no combinational path from btn_raw.

Reset
REQ-027 On rst=1, synchronizers, key_state, debounce counters, repeat counters, op_keys and any_press SHALL be 0, and all FSMs SHALL be in IDLE, asynchronously.
REQ-028 After rst deasserts, a key already held SHALL be treated as a fresh press: debounce from 0, then one pulse.
REQ-029 Assertion of rst mid-press or mid-repeat SHALL drop any pending pulse, with no pulse in the cycle rst deasserts.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8)
REQ-030 Clean press: btn_raw[2] high at edge 0 and held -> key_state[2] and op_keys[2]=1 at edge 6 only, then op_keys[2] pulses at 26, 34, 42; any_press matches.
REQ-031 Bounce: btn_raw[1] toggling every 2 cycles for 30 cycles, then low -> key_state[1] and op_keys[1] stay 0 throughout.
REQ-032 Non-repeat key: btn_raw[0] held 100 cycles -> exactly one op_keys[0] pulse at edge 6 and no pulse on release.
REQ-033 Simultaneous: btn_raw[3:2]=2'b11 at edge 0 -> op_keys=4'b1100 at edge 6 and repeats coincide thereafter.
REQ-034 Early release: btn_raw[3] held 15 cycles -> one pulse at edge 6, key_state[3] falls at edge 21, and no repeat pulse occurs.
REQ-035 Reset mid-repeat: rst pulsed at edge 30 with btn_raw[2] held -> outputs 0 immediately, then a fresh pulse 6 edges after rst release.
